// File: rtl/acc_cpu_core.sv
// rtl/acc_cpu_core.sv - parametrised multi-cycle accumulator processor core
//
// Purpose:
//   Accumulator CPU executing one instruction per FETCH/DECODE/[MEM]/EXEC pass
//   over a single unified instruction/data memory port with req/ack handshake.
//   Instruction word: opcode = [DATA_W-1:DATA_W-4], field F = [ADDR_W-1:0].
//   DATA_W must be at least ADDR_W+4.
//
// Ports:
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   mem_req, mem_we   transaction request / write strobe (registered-state decode)
//   mem_addr          transaction address (PC in FETCH, F in MEM)
//   mem_wdata         write data, always the accumulator
//   mem_rdata         read data, captured on the acknowledging edge
//   mem_ack           completes a transaction on an edge where mem_req=1
//   ac_out, pc_out    accumulator and program counter
//   flag_z, flag_c    zero and carry/borrow flags
//   halted            core sits in HALT until reset
//   perf_retired      retired-instruction counter (only with ACC_CPU_PERF_EN)
//
// Configuration macro: ACC_CPU_PERF_EN adds the perf_retired counter port.

module acc_cpu_core #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] ac_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              flag_z,
  output logic              flag_c,
  output logic              halted
`ifdef ACC_CPU_PERF_EN
  ,
  output logic [31:0]       perf_retired
`endif
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_MEM,
    S_EXEC,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_NOT = 4'h8;
  localparam logic [3:0] OP_SHL = 4'h9;
  localparam logic [3:0] OP_SHR = 4'hA;
  localparam logic [3:0] OP_JMP = 4'hB;
  localparam logic [3:0] OP_JZ  = 4'hC;
  localparam logic [3:0] OP_JC  = 4'hD;
  localparam logic [3:0] OP_LDI = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t              state;
  state_t              state_nx;
  logic [ADDR_W-1:0]   pc;
  logic [DATA_W-1:0]   ac;
  logic [DATA_W-1:0]   opnd;
  logic [3:0]          ir_op;
  logic [ADDR_W-1:0]   ir_f;
  logic                z;
  logic                c;

  logic                mem_op;
  logic [DATA_W:0]     sum;
  logic [DATA_W:0]     diff;
  logic [DATA_W-1:0]   ac_nx;
  logic [ADDR_W-1:0]   pc_nx;
  logic                c_nx;
  logic                ac_wr;

  // Operand-fetching opcodes take the extra MEM state.
  always_comb begin
    mem_op = 1'b0;
    case (ir_op)
      OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: mem_op = 1'b1;
      default: mem_op = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = pc;
    halted   = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) state_nx = S_DECODE;
      end
      S_DECODE: begin
        if (ir_op == OP_HLT) state_nx = S_HALT;
        else if (mem_op)     state_nx = S_MEM;
        else                 state_nx = S_EXEC;
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_we   = (ir_op == OP_STA);
        mem_addr = ir_f;
        if (mem_ack) state_nx = S_EXEC;
      end
      S_EXEC: begin
        state_nx = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_nx = S_FETCH;
      end
    endcase
    // Reset forces state to FETCH, which would otherwise request; keep the
    // memory port quiet for as long as rst_n is held low.
    if (!rst_n) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
    end
  end

  always_comb begin
    sum  = {1'b0, ac} + {1'b0, opnd};
    diff = {1'b0, ac} - {1'b0, opnd};
  end

  // EXEC result. The top bit of the widened difference is the unsigned borrow.
  always_comb begin
    ac_nx = ac;
    c_nx  = c;
    pc_nx = pc;
    ac_wr = 1'b1;
    case (ir_op)
      OP_LDA: ac_nx = opnd;
      OP_ADD: {c_nx, ac_nx} = sum;
      OP_SUB: begin
        ac_nx = diff[DATA_W-1:0];
        c_nx  = diff[DATA_W];
      end
      OP_AND: ac_nx = ac & opnd;
      OP_OR:  ac_nx = ac | opnd;
      OP_XOR: ac_nx = ac ^ opnd;
      OP_NOT: ac_nx = ~ac;
      OP_SHL: begin
        c_nx  = ac[DATA_W-1];
        ac_nx = {ac[DATA_W-2:0], 1'b0};
      end
      OP_SHR: begin
        c_nx  = ac[0];
        ac_nx = {1'b0, ac[DATA_W-1:1]};
      end
      OP_JMP: begin
        pc_nx = ir_f;
        ac_wr = 1'b0;
      end
      OP_JZ: begin
        if (z) pc_nx = ir_f;
        ac_wr = 1'b0;
      end
      OP_JC: begin
        if (c) pc_nx = ir_f;
        ac_wr = 1'b0;
      end
      OP_LDI: ac_nx = {{(DATA_W-ADDR_W){1'b0}}, ir_f};
      OP_NOP, OP_STA, OP_HLT: ac_wr = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= '0;
      ac    <= '0;
      opnd  <= '0;
      ir_op <= '0;
      ir_f  <= '0;
      z     <= 1'b0;
      c     <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (mem_ack) begin
            ir_op <= mem_rdata[DATA_W-1 -: 4];
            ir_f  <= mem_rdata[ADDR_W-1:0];
            pc    <= pc + ADDR_W'(1);
          end
        end
        S_MEM: begin
          if (mem_ack && ir_op != OP_STA) opnd <= mem_rdata;
        end
        S_EXEC: begin
          ac <= ac_nx;
          c  <= c_nx;
          pc <= pc_nx;
          if (ac_wr) z <= (ac_nx == '0);
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_wdata = ac;
  assign ac_out    = ac;
  assign pc_out    = pc;
  assign flag_z    = z;
  assign flag_c    = c;

`ifdef ACC_CPU_PERF_EN
  logic [31:0] perf_cnt;

  // An instruction retires on leaving EXEC, or on DECODE->HALT for HLT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cnt <= '0;
    end else if (state == S_EXEC || (state == S_DECODE && ir_op == OP_HLT)) begin
      perf_cnt <= perf_cnt + 32'd1;
    end
  end

  assign perf_retired = perf_cnt;
`endif

endmodule
